tma_issue_sched: RTL and testbench
==================================

Name: tma_issue_sched

Overview:
- Shares the single TMA copy engine among NUM_REQS requesters (warp slots).
- Each requester owns a one-deep descriptor slot. A round-robin arbiter picks a pending slot and issues it to the engine.
- The block waits for the engine's completion and returns it to the owning requester on one completion channel.
- Sits between the warp issue/LSU side and the TMA engine's instruction request/done ports.

Parameters:
- NUM_REQS, 4, number of requesters/slots (≥2).
- USER_TAGW, 8, requester-supplied tag width.
- IDX_W, $clog2(NUM_REQS), slot index width (derived).
- ENG_TAGW, IDX_W+USER_TAGW, engine tag width (derived); engine tag = {slot_idx, user_tag}.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  NUM_REQS  per-requester submit valid
- in_desc  in  NUM_REQS x $bits(tma_desc_t)  per-requester descriptor
- in_tag  in  NUM_REQS x USER_TAGW  per-requester user tag
- in_ready  out  NUM_REQS  slot free (registered)
- eng_req_valid  out  1  issue to engine
- eng_req_desc  out  $bits(tma_desc_t)  issued descriptor
- eng_req_tag  out  ENG_TAGW  {slot_idx, user_tag}
- eng_req_ready  in  1  engine accepts
- eng_done_valid  in  1  engine completion
- eng_done_tag  in  ENG_TAGW  completion tag
- eng_done_ready  out  1  completion accepted
- out_done_valid  out  1  completion to requester
- out_done_idx  out  IDX_W  owning slot
- out_done_tag  out  USER_TAGW  user tag echoed
- out_done_ready  in  1  requester side accepts
- tag_err  out  1  sticky: engine completion tag did not match in-flight tag

Behaviour:
- Slot states: FREE, PENDING, ACTIVE.
  - in_ready[i] = (slot i FREE), decoded from registers only.
  - in_valid[i] && in_ready[i] at cycle t: capture desc/tag; slot is PENDING at t+1.
- Controller FSM states: S_IDLE, S_ISSUE, S_BUSY, S_NOTIFY.
- S_IDLE: if any slot is PENDING, the RR arbiter picks a winner.
  - Register winner index, desc and engine tag; winner slot goes ACTIVE.
  - Go to S_ISSUE next cycle. Earliest eng_req_valid is t+2 after the submit handshake.
- S_ISSUE: eng_req_valid=1 with stable desc/tag until eng_req_ready.
  - On the handshake, the RR pointer becomes winner+1 (mod NUM_REQS); go to S_BUSY.
- S_BUSY: eng_done_ready=1.
  - On eng_done_valid, capture the tag.
  - If captured tag ≠ registered engine tag, set tag_err (sticky until reset); completion is still processed for the ACTIVE slot.
  - Go to S_NOTIFY.
- S_NOTIFY: out_done_valid=1, out_done_idx=active idx, out_done_tag=active user tag; hold until out_done_ready.
  - On the handshake, the slot goes FREE and the FSM returns to S_IDLE.
  - The freed slot's in_ready rises the next cycle; it is never combinationally ready in the release cycle.
- eng_done_ready=0 outside S_BUSY; a stray eng_done_valid is not consumed.
- RR arbitration: scan from pointer upward with wrap; lowest index ≥ pointer wins, else lowest index overall. Pointer is 0 after reset.
- Submits to other slots are accepted in any FSM state. The ACTIVE slot never accepts.
- At most one descriptor is outstanding at the engine.
- Reset (async, any time, including mid-issue or mid-notify):
  - All slots FREE; FSM S_IDLE; pointer 0; tag_err 0.
  - in_ready all 1 after deassertion; eng_req_valid, eng_done_ready, out_done_valid all 0 immediately.
  - Slot payload registers need not be reset.

Optional Feature:
- Macro: TMA_SCHED_PERF_EN.
- Defined: adds three 32-bit wrapping output counters, all cleared by reset:
  - perf_issued: eng_req handshakes.
  - perf_stall: cycles with eng_req_valid && !eng_req_ready.
  - perf_wait: sum over cycles of the PENDING slot count.
- Undefined: these ports and registers do not exist.

Decomposition:
- VX_tma_pkg holds tma_desc_t and adds:
  - a tma_sched_state_e enum (S_IDLE..S_NOTIFY);
  - a slot-state enum;
  - a helper constant for engine tag layout (IDX field in MSBs).
- Sub-module tma_sched_rr_arb: purely combinational pending-mask + pointer → one-hot grant + index. The pointer register stays in the parent.

Test Plan:
- Single submit: slot 2, tag 0x5A at t0 → eng_req_valid at t0+2 with eng_req_tag={2,0x5A}. Engine done with the same tag → out_done_idx=2, out_done_tag=0x5A; in_ready[2] back to 1 one cycle after the out_done handshake.
- Fairness: slots 0..3 all submit in the same cycle, engine completes immediately each time → issue order 0,1,2,3. Slot 0 resubmits while slot 1 is active → order continues 2,3,0.
- Backpressure: eng_req_ready held low 5 cycles → eng_req_valid/desc/tag stable for all 5 cycles. out_done_ready low 3 cycles → slot stays ACTIVE and in_ready stays 0.
- Tag mismatch: engine returns {1,0x00} while {3,0x11} is active → tag_err=1 and stays 1, out_done_idx=3; only reset clears it.
- Reset mid-operation: assert reset during S_ISSUE → eng_req_valid drops in the same cycle, all in_ready=1 after release, the next issue starts from slot 0.
- Perf (TMA_SCHED_PERF_EN): 4 issues with 2 stall cycles each → perf_issued=4, perf_stall=8.

Source files
------------

// File: rtl/VX_tma_pkg.sv
// TMA shared types: descriptor, scheduler FSM/slot state encodings, engine tag layout.
// Latency: n/a (types only).
// Backpressure: n/a.
package VX_tma_pkg;

   // One TMA copy descriptor as handed to the engine.
   typedef struct packed {
      logic [31:0] gmem_addr;
      logic [15:0] smem_addr;
      logic [15:0] size;
   } tma_desc_t;

   // Issue scheduler controller states.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_BUSY   = 2'd2,
      S_NOTIFY = 2'd3
   } tma_sched_state_e;

   // Per-requester descriptor slot state.
   typedef enum logic [1:0] {
      SLOT_FREE    = 2'd0,
      SLOT_PENDING = 2'd1,
      SLOT_ACTIVE  = 2'd2
   } tma_slot_state_e;

   // Engine tag = {slot_idx, user_tag}: the slot index field starts right above the user tag.
   function automatic int unsigned eng_tag_idx_lsb(input int unsigned user_tagw);
      return user_tagw;
   endfunction

endpackage

// File: rtl/tma_sched_rr_arb.sv
// Round-robin pick: lowest pending index at or above ptr, else lowest pending overall.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module tma_sched_rr_arb #(
   parameter int NUM_REQS = 4,
   parameter int IDX_W    = $clog2(NUM_REQS)
) (
   input  logic [NUM_REQS-1:0] pending,
   input  logic [IDX_W-1:0]    ptr,
   output logic [NUM_REQS-1:0] grant,
   output logic [IDX_W-1:0]    grant_idx,
   output logic                grant_vld
);

   // Two-pass scan: first the upper window [ptr, N), then wrap to the whole range.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (!grant_vld && pending[i] && (i >= int'(ptr))) begin
            grant_vld = 1'b1;
            grant_idx = IDX_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQS; i++) begin
         if (!grant_vld && pending[i]) begin
            grant_vld = 1'b1;
            grant_idx = IDX_W'(i);
         end
      end
      if (grant_vld) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/tma_issue_sched.sv
// Shares one TMA engine among NUM_REQS one-deep descriptor slots, round-robin, one in flight.
// Latency: submit handshake at t -> eng_req_valid at t+2; in_ready returns the cycle after out_done handshake.
// Backpressure: holds eng_req until eng_req_ready, completion until out_done_ready; optional TMA_SCHED_PERF_EN adds perf counters.
module tma_issue_sched
   import VX_tma_pkg::*;
#(
   parameter int NUM_REQS  = 4,
   parameter int USER_TAGW = 8,
   parameter int IDX_W     = $clog2(NUM_REQS),
   parameter int ENG_TAGW  = IDX_W + USER_TAGW
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_REQS-1:0]                 in_valid,
   input  tma_desc_t [NUM_REQS-1:0]            in_desc,
   input  logic [NUM_REQS-1:0][USER_TAGW-1:0]  in_tag,
   output logic [NUM_REQS-1:0]                 in_ready,
   output logic                                eng_req_valid,
   output tma_desc_t                           eng_req_desc,
   output logic [ENG_TAGW-1:0]                 eng_req_tag,
   input  logic                                eng_req_ready,
   input  logic                                eng_done_valid,
   input  logic [ENG_TAGW-1:0]                 eng_done_tag,
   output logic                                eng_done_ready,
   output logic                                out_done_valid,
   output logic [IDX_W-1:0]                    out_done_idx,
   output logic [USER_TAGW-1:0]                out_done_tag,
   input  logic                                out_done_ready,
   output logic                                tag_err
`ifdef TMA_SCHED_PERF_EN
   ,
   output logic [31:0]                         perf_issued,
   output logic [31:0]                         perf_stall,
   output logic [31:0]                         perf_wait
`endif
);

   localparam int IDX_LSB = eng_tag_idx_lsb(USER_TAGW);

   tma_slot_state_e                     slot_state [NUM_REQS];
   tma_desc_t [NUM_REQS-1:0]            slot_desc;
   logic [NUM_REQS-1:0][USER_TAGW-1:0]  slot_tag;

   tma_sched_state_e    state, state_nxt;
   logic [IDX_W-1:0]    rr_ptr;
   logic [IDX_W-1:0]    act_idx;
   tma_desc_t           act_desc;
   logic [ENG_TAGW-1:0] act_etag;

   logic [NUM_REQS-1:0] pending;
   logic [NUM_REQS-1:0] grant;
   logic [IDX_W-1:0]    grant_idx;
   logic                grant_vld;
   logic                pick;
   logic                req_fire;
   logic                done_fire;
   logic                notify_fire;

   // Slot status decode; in_ready comes straight from slot state registers.
   always_comb begin
      in_ready = '0;
      pending  = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         in_ready[i] = (slot_state[i] == SLOT_FREE);
         pending[i]  = (slot_state[i] == SLOT_PENDING);
      end
   end

   tma_sched_rr_arb #(
      .NUM_REQS (NUM_REQS),
      .IDX_W    (IDX_W)
   ) u_arb (
      .pending   (pending),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   assign pick        = (state == S_IDLE) && grant_vld;
   assign req_fire    = eng_req_valid && eng_req_ready;
   assign done_fire   = eng_done_valid && eng_done_ready;
   assign notify_fire = out_done_valid && out_done_ready;

   assign eng_req_desc = act_desc;
   assign eng_req_tag  = act_etag;
   assign out_done_idx = act_idx;
   assign out_done_tag = act_etag[USER_TAGW-1:0];

   // Controller next-state and handshake outputs, all decoded from the state register.
   always_comb begin
      state_nxt      = state;
      eng_req_valid  = 1'b0;
      eng_done_ready = 1'b0;
      out_done_valid = 1'b0;
      case (state)
         S_IDLE: begin
            if (grant_vld) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            eng_req_valid = 1'b1;
            if (eng_req_ready) state_nxt = S_BUSY;
         end
         S_BUSY: begin
            eng_done_ready = 1'b1;
            if (eng_done_valid) state_nxt = S_NOTIFY;
         end
         S_NOTIFY: begin
            out_done_valid = 1'b1;
            if (out_done_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Controller state, round-robin pointer and sticky tag error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         rr_ptr  <= '0;
         tag_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (req_fire) begin
            rr_ptr <= (act_idx == IDX_W'(NUM_REQS - 1)) ? '0 : act_idx + IDX_W'(1);
         end
         if (done_fire && (eng_done_tag != act_etag)) begin
            tag_err <= 1'b1;
         end
      end
   end

   // Per-slot lifecycle: FREE -> PENDING on submit, -> ACTIVE on grant, -> FREE on notify.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQS; i++) slot_state[i] <= SLOT_FREE;
      end else begin
         for (int i = 0; i < NUM_REQS; i++) begin
            case (slot_state[i])
               SLOT_FREE:    if (in_valid[i]) slot_state[i] <= SLOT_PENDING;
               SLOT_PENDING: if (pick && grant[i]) slot_state[i] <= SLOT_ACTIVE;
               SLOT_ACTIVE:  if (notify_fire && (act_idx == IDX_W'(i))) slot_state[i] <= SLOT_FREE;
               default:      slot_state[i] <= SLOT_FREE;
            endcase
         end
      end
   end

   // Slot payload capture; contents are only meaningful while the slot is not FREE.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQS; i++) begin
         if (in_valid[i] && in_ready[i]) begin
            slot_desc[i] <= in_desc[i];
            slot_tag[i]  <= in_tag[i];
         end
      end
   end

   // Latch the winner so the engine sees stable desc/tag for the whole issue phase.
   always_ff @(posedge clk) begin
      if (pick) begin
         act_idx                           <= grant_idx;
         act_desc                          <= slot_desc[grant_idx];
         act_etag[ENG_TAGW-1:IDX_LSB]      <= grant_idx;
         act_etag[IDX_LSB-1:0]             <= slot_tag[grant_idx];
      end
   end

`ifdef TMA_SCHED_PERF_EN
   logic [31:0] pend_cnt;

   // Number of slots waiting for the engine this cycle.
   always_comb begin
      pend_cnt = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         pend_cnt = pend_cnt + 32'(pending[i]);
      end
   end

   // Wrapping performance counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_issued <= '0;
         perf_stall  <= '0;
         perf_wait   <= '0;
      end else begin
         if (req_fire) perf_issued <= perf_issued + 32'd1;
         if (eng_req_valid && !eng_req_ready) perf_stall <= perf_stall + 32'd1;
         perf_wait <= perf_wait + pend_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_tma_issue_sched.sv
// Directed bench for tma_issue_sched: table of single-slot transactions plus fairness,
// backpressure, tag-mismatch and mid-issue reset sequences.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_tma_issue_sched;
   import VX_tma_pkg::*;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [3:0]            in_valid;
   tma_desc_t [3:0]       in_desc;
   logic [3:0][7:0]       in_tag;
   logic [3:0]            in_ready;
   logic                  eng_req_valid;
   tma_desc_t             eng_req_desc;
   logic [9:0]            eng_req_tag;
   logic                  eng_req_ready;
   logic                  eng_done_valid;
   logic [9:0]            eng_done_tag;
   logic                  eng_done_ready;
   logic                  out_done_valid;
   logic [1:0]            out_done_idx;
   logic [7:0]            out_done_tag;
   logic                  out_done_ready;
   logic                  tag_err;
`ifdef TMA_SCHED_PERF_EN
   logic [31:0]           perf_issued, perf_stall, perf_wait;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tma_issue_sched dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_desc        (in_desc),
      .in_tag         (in_tag),
      .in_ready       (in_ready),
      .eng_req_valid  (eng_req_valid),
      .eng_req_desc   (eng_req_desc),
      .eng_req_tag    (eng_req_tag),
      .eng_req_ready  (eng_req_ready),
      .eng_done_valid (eng_done_valid),
      .eng_done_tag   (eng_done_tag),
      .eng_done_ready (eng_done_ready),
      .out_done_valid (out_done_valid),
      .out_done_idx   (out_done_idx),
      .out_done_tag   (out_done_tag),
      .out_done_ready (out_done_ready),
      .tag_err        (tag_err)
`ifdef TMA_SCHED_PERF_EN
      ,
      .perf_issued    (perf_issued),
      .perf_stall     (perf_stall),
      .perf_wait      (perf_wait)
`endif
   );

   typedef struct {
      int         slot;
      logic [7:0] tag;
      logic [9:0] exp_etag;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic tma_desc_t mk_desc(input logic [7:0] t);
      tma_desc_t d;
      d.gmem_addr = {24'hA00000, t};
      d.smem_addr = {8'h5C, t};
      d.size      = {8'h01, ~t};
      return d;
   endfunction

   task automatic submit(input int slot, input logic [7:0] tag);
      in_valid[slot] = 1'b1;
      in_desc[slot]  = mk_desc(tag);
      in_tag[slot]   = tag;
      step();
      in_valid = '0;
   endtask

   task automatic wait_issue();
      int n = 0;
      while (!eng_req_valid && n < 50) begin
         step();
         n++;
      end
      check("issue_wait", {63'd0, eng_req_valid}, 64'd1);
   endtask

   task automatic accept();
      eng_req_ready = 1'b1;
      step();
      eng_req_ready = 1'b0;
   endtask

   // Engine completion, then requester notify with an optional hold of out_done_ready.
   task automatic finish(input int slot, input logic [7:0] utag, input logic [9:0] dtag, input int hold_n);
      int n = 0;
      eng_done_valid = 1'b1;
      eng_done_tag   = dtag;
      while (!eng_done_ready && n < 50) begin
         step();
         n++;
      end
      check("done_ready_wait", {63'd0, eng_done_ready}, 64'd1);
      step();
      eng_done_valid = 1'b0;
      n = 0;
      while (!out_done_valid && n < 50) begin
         step();
         n++;
      end
      check("out_done_wait", {63'd0, out_done_valid}, 64'd1);
      for (int k = 0; k < hold_n; k++) begin
         check("notify_hold_valid", {63'd0, out_done_valid}, 64'd1);
         check("notify_hold_in_ready", {63'd0, in_ready[slot]}, 64'd0);
         step();
      end
      check("out_done_idx", 64'(out_done_idx), 64'(slot));
      check("out_done_tag", 64'(out_done_tag), 64'(utag));
      out_done_ready = 1'b1;
      check("in_ready_release_cycle", {63'd0, in_ready[slot]}, 64'd0);
      step();
      out_done_ready = 1'b0;
      check("in_ready_after_release", {63'd0, in_ready[slot]}, 64'd1);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      int exp_order [5];
      logic [7:0] ftag;

      vecs[0] = '{slot: 2, tag: 8'h5A, exp_etag: 10'h25A};
      vecs[1] = '{slot: 0, tag: 8'h01, exp_etag: 10'h001};
      vecs[2] = '{slot: 3, tag: 8'hFF, exp_etag: 10'h3FF};
      vecs[3] = '{slot: 1, tag: 8'h80, exp_etag: 10'h180};
      exp_order = '{0, 1, 2, 3, 0};

      reset          = 1'b1;
      in_valid       = '0;
      in_desc        = '0;
      in_tag         = '0;
      eng_req_ready  = 1'b0;
      eng_done_valid = 1'b0;
      eng_done_tag   = '0;
      out_done_ready = 1'b0;
      #1;
      check("rst_eng_req_valid", {63'd0, eng_req_valid}, 64'd0);
      check("rst_eng_done_ready", {63'd0, eng_done_ready}, 64'd0);
      check("rst_out_done_valid", {63'd0, out_done_valid}, 64'd0);
      check("rst_tag_err", {63'd0, tag_err}, 64'd0);
      step();
      step();
      reset = 1'b0;
      step();
      check("rst_in_ready", 64'(in_ready), 64'hF);

      // Single-slot transactions, one per table entry.
      for (int v = 0; v < 4; v++) begin
         submit(vecs[v].slot, vecs[v].tag);
         check("submit_in_ready_low", {63'd0, in_ready[vecs[v].slot]}, 64'd0);
         check("latency_t1_no_req", {63'd0, eng_req_valid}, 64'd0);
         step();
         check("latency_t2_req", {63'd0, eng_req_valid}, 64'd1);
         check("issue_tag", 64'(eng_req_tag), 64'(vecs[v].exp_etag));
         check("issue_desc", 64'(eng_req_desc), 64'(mk_desc(vecs[v].tag)));
         accept();
         finish(vecs[v].slot, vecs[v].tag, vecs[v].exp_etag, 0);
      end

      // Fairness: all four submit together; slot 0 resubmits while slot 1 is active.
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         in_valid[i] = 1'b1;
         in_desc[i]  = mk_desc(8'h10 + 8'(i));
         in_tag[i]   = 8'h10 + 8'(i);
      end
      step();
      in_valid = '0;
      for (int k = 0; k < 5; k++) begin
         ftag = 8'h10 + 8'(exp_order[k]);
         wait_issue();
         check("fair_order", 64'(eng_req_tag), 64'({2'(exp_order[k]), ftag}));
         accept();
         if (k == 1) submit(0, 8'h10);
         finish(exp_order[k], ftag, {2'(exp_order[k]), ftag}, 0);
      end

      // Engine request backpressure, then requester-side backpressure.
      submit(1, 8'h42);
      wait_issue();
      for (int c = 0; c < 5; c++) begin
         check("bp_req_valid", {63'd0, eng_req_valid}, 64'd1);
         check("bp_req_desc", 64'(eng_req_desc), 64'(mk_desc(8'h42)));
         check("bp_req_tag", 64'(eng_req_tag), 64'h142);
         step();
      end
      accept();
      finish(1, 8'h42, 10'h142, 3);

      // Completion tag mismatch is sticky; the active slot still completes.
      submit(3, 8'h11);
      wait_issue();
      accept();
      finish(3, 8'h11, 10'h100, 0);
      check("tag_err_set", {63'd0, tag_err}, 64'd1);
      submit(2, 8'h22);
      wait_issue();
      accept();
      finish(2, 8'h22, 10'h222, 0);
      check("tag_err_sticky", {63'd0, tag_err}, 64'd1);

      // Reset while issuing (pointer is 3 here); next arbitration restarts from slot 0.
      submit(1, 8'h33);
      wait_issue();
      reset = 1'b1;
      #1;
      check("midrst_req_valid", {63'd0, eng_req_valid}, 64'd0);
      check("midrst_tag_err", {63'd0, tag_err}, 64'd0);
      step();
      reset = 1'b0;
      step();
      check("midrst_in_ready", 64'(in_ready), 64'hF);
      check("midrst_no_req", {63'd0, eng_req_valid}, 64'd0);
      in_valid = 4'b1001;
      in_desc[0] = mk_desc(8'h40);
      in_tag[0]  = 8'h40;
      in_desc[3] = mk_desc(8'h43);
      in_tag[3]  = 8'h43;
      step();
      in_valid = '0;
      wait_issue();
      check("midrst_first_slot0", 64'(eng_req_tag), 64'h040);
      accept();
      finish(0, 8'h40, 10'h040, 0);
      wait_issue();
      check("midrst_second_slot3", 64'(eng_req_tag), 64'h343);
      accept();
      finish(3, 8'h43, 10'h343, 0);

`ifdef TMA_SCHED_PERF_EN
      pulse_reset();
      for (int k = 0; k < 4; k++) begin
         submit(k, 8'(k));
         wait_issue();
         step();
         step();
         accept();
         finish(k, 8'(k), {2'(k), 8'(k)}, 0);
      end
      check("perf_issued", 64'(perf_issued), 64'd4);
      check("perf_stall", 64'(perf_stall), 64'd8);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
